// File: rtl/cfg_stream_tx.sv
// Serialises one config frame per start: an 8-bit tile id followed by MEM_BYTES
// payload bytes, MSB first, with a fixed idle gap and a done pulse at the end.
module cfg_stream_tx #(
  parameter int unsigned MEM_BYTES  = 4096,
  parameter int unsigned GAP_CYCLES = 2,
  parameter int unsigned NUM_TILES  = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] tile_id,
  input  logic [7:0] in_byte,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       serial_out,
  output logic       serial_valid,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [1:0] {S_IDLE, S_ID, S_PAYLOAD, S_GAP} state_e;

  localparam logic [12:0] MEM_BYTES_C = 13'(MEM_BYTES);
  localparam logic [3:0]  GAP_LAST_C  = 4'(GAP_CYCLES - 1);

  state_e      state_q, state_d;
  logic [7:0]  id_q, id_d;
  logic [2:0]  id_bit_q, id_bit_d;
  logic [7:0]  hold_q, hold_d;
  logic        hold_full_q, hold_full_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [3:0]  sh_cnt_q, sh_cnt_d;
  logic [12:0] acc_cnt_q, acc_cnt_d;
  logic [12:0] sent_cnt_q, sent_cnt_d;
  logic [3:0]  gap_cnt_q, gap_cnt_d;
  logic        err_q, err_d;

  logic tile_ok;
  logic accept;
  logic load;

  assign tile_ok = 32'(tile_id) < NUM_TILES;
  assign accept  = in_valid && in_ready;
  // Refill the shifter from the holding byte on its last bit (or when empty) so
  // the bit stream stays gapless; the last ID cycle also counts, for prefetch.
  assign load = hold_full_q &&
                ((state_q == S_ID && id_bit_q == 3'd7) ||
                 (state_q == S_PAYLOAD && sh_cnt_q <= 4'd1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      id_q        <= '0;
      id_bit_q    <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shreg_q     <= '0;
      sh_cnt_q    <= '0;
      acc_cnt_q   <= '0;
      sent_cnt_q  <= '0;
      gap_cnt_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      id_bit_q    <= id_bit_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shreg_q     <= shreg_d;
      sh_cnt_q    <= sh_cnt_d;
      acc_cnt_q   <= acc_cnt_d;
      sent_cnt_q  <= sent_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    id_bit_d    = id_bit_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shreg_d     = shreg_q;
    sh_cnt_d    = sh_cnt_q;
    acc_cnt_d   = acc_cnt_q;
    sent_cnt_d  = sent_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    err_d       = err_q;

    if (accept) begin
      hold_d      = in_byte;
      hold_full_d = 1'b1;
      acc_cnt_d   = acc_cnt_q + 13'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (tile_ok) begin
            state_d     = S_ID;
            id_d        = tile_id;
            id_bit_d    = '0;
            err_d       = 1'b0;
            hold_full_d = 1'b0;
            sh_cnt_d    = '0;
            acc_cnt_d   = '0;
            sent_cnt_d  = '0;
            gap_cnt_d   = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_ID: begin
        id_bit_d = id_bit_q + 3'd1;
        if (id_bit_q == 3'd7) state_d = S_PAYLOAD;
      end
      S_PAYLOAD: begin
        if (sh_cnt_q != 4'd0) begin
          shreg_d  = {shreg_q[6:0], 1'b0};
          sh_cnt_d = sh_cnt_q - 4'd1;
          if (sh_cnt_q == 4'd1) begin
            sent_cnt_d = sent_cnt_q + 13'd1;
            if (sent_cnt_q + 13'd1 == MEM_BYTES_C) begin
              state_d   = S_GAP;
              gap_cnt_d = '0;
            end
          end
        end
      end
      S_GAP: begin
        gap_cnt_d = gap_cnt_q + 4'd1;
        if (gap_cnt_q == GAP_LAST_C) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (load) begin
      shreg_d     = hold_q;
      sh_cnt_d    = 4'd8;
      hold_full_d = 1'b0;
    end
  end

  always_comb begin
    in_ready     = (state_q == S_ID || state_q == S_PAYLOAD) && !hold_full_q &&
                   (acc_cnt_q < MEM_BYTES_C);
    serial_valid = (state_q == S_ID) || (state_q == S_PAYLOAD && sh_cnt_q != 4'd0);
    serial_out   = 1'b0;
    if (state_q == S_ID) begin
      serial_out = id_q[3'd7 - id_bit_q];
    end else if (state_q == S_PAYLOAD && sh_cnt_q != 4'd0) begin
      serial_out = shreg_q[7];
    end
    busy = (state_q != S_IDLE);
    done = (state_q == S_GAP) && (gap_cnt_q == GAP_LAST_C);
    err  = err_q;
  end

endmodule

// File: doc/cfg_stream_tx.md
CFG_STREAM_TX -- requirements
Module: cfg_stream_tx

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 4096: payload bytes per frame, range 1..4096.
REQ-002 SHALL have parameter GAP_CYCLES, default 2: idle cycles after each frame, range 1..15.
REQ-003 SHALL have parameter NUM_TILES, default 9: legal tile ids are 0..NUM_TILES-1.
REQ-004 clk  in  1  sole clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 start  in  1  one-cycle frame request, sampled in IDLE only.
REQ-007 tile_id  in  8  destination tile, captured with start.
REQ-008 in_byte  in  8  payload byte from the config source.
REQ-009 in_valid  in  1  in_byte valid.
REQ-010 in_ready  out  1  byte accepted on cycles where in_valid && in_ready.
REQ-011 serial_out  out  1  serial bit line, MSB first.
REQ-012 serial_valid  out  1  qualifies serial_out; tile receivers shift on each cycle it is high.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 done  out  1  one-cycle pulse when a frame completes.
REQ-015 err  out  1  sticky; set on an illegal tile_id; cleared by rst or the next accepted start.

Function
REQ-016 SHALL implement states IDLE, ID, PAYLOAD, GAP.
REQ-017 IDLE: start with tile_id < NUM_TILES -> latch id, enter ID next cycle; start with tile_id >= NUM_TILES -> set err, stay IDLE.
REQ-018 start while busy SHALL be ignored, with no effect on state or err.
REQ-019 ID: exactly 8 consecutive cycles, serial_valid=1, serial_out = id[7-k] on cycle k (k=0..7), then PAYLOAD.
REQ-020 Buffering: one holding register plus an 8-bit shift register; in_ready = (state is ID or PAYLOAD) && holding empty && bytes_accepted < MEM_BYTES.
REQ-021 Bytes MAY be accepted during ID (prefetch), so PAYLOAD can start with no bubble.
REQ-022 PAYLOAD: when the shift register is empty or on its last bit, the holding byte SHALL transfer into it the same cycle, giving a gapless bit stream while data is supplied.
REQ-023 Underrun (shift register empty, holding empty): serial_valid=0 and serial_out=0 until a byte arrives; a partial byte SHALL never be stalled mid-byte once started.
REQ-024 Each byte SHALL be sent MSB first over 8 serial_valid cycles.
REQ-025 bytes_accepted and bytes_sent counters SHALL be 13 bits wide and never exceed MEM_BYTES.
REQ-026 After the 8th bit of byte MEM_BYTES: enter GAP with serial_valid=0 for GAP_CYCLES cycles.
REQ-027 On the last GAP cycle: done=1, then IDLE.
REQ-028 Total frame length with no underrun SHALL be 8 + 8*MEM_BYTES serial_valid cycles, contiguous.
REQ-029 serial_out SHALL be 0 whenever serial_valid=0.

Reset
REQ-030 rst SHALL force IDLE; serial_out=0, serial_valid=0, in_ready=0, busy=0, done=0, err=0; counters, id, holding register and shift register cleared.
REQ-031 rst mid-frame SHALL abort immediately, with no done pulse and no further serial_valid; a buffered byte is discarded.
REQ-032 rst has priority over start on the same cycle.

Verification
REQ-033 MEM_BYTES=2, tile_id=0x05, bytes A5,3C with in_valid held high -> serial_valid high 24 consecutive cycles; bits 00000101 10100101 00111100; GAP 2 cycles; done pulse; busy falls next cycle.
REQ-034 Same frame, in_valid dropped for 5 cycles after byte 1 accepted -> byte 1 completes, then serial_valid=0 for the stall; byte 2 resumes intact; total 24 valid cycles.
REQ-035 start with tile_id=9 (NUM_TILES=9) -> err=1, busy stays 0; next start with tile_id=2 -> err clears, frame proceeds.
REQ-036 start pulsed during PAYLOAD -> ignored; exactly one done per frame.
REQ-037 rst asserted on the 3rd payload bit -> next cycle all outputs 0 and state IDLE; a new start produces a full correct frame.
REQ-038 MEM_BYTES=1, GAP_CYCLES=1 -> 16 valid cycles, then 1 gap cycle with done; back-to-back start the cycle after done is accepted.
